// File: rtl/mux_rr_stream.sv
// Round-robin N:1 stream multiplexer with a registered output beat.
// Define MUX_RR_STREAM_LAST_LOCK_EN to hold the grant on one channel until its last_in beat.
module mux_rr_stream #(
    parameter int CH = 4,
    parameter int W  = 8,
    localparam int SW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [CH*W-1:0] d_in,
    input  logic [CH-1:0]   valid_in,
    output logic [CH-1:0]   ready_out,
    output logic [W-1:0]    out,
    output logic            valid_out,
    input  logic            ready_in,
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
    input  logic [CH-1:0]   last_in,
    output logic            last_out,
`endif
    output logic [SW-1:0]   sel_out
);

    logic          load;
    logic [SW-1:0] ptr;
    logic          grant_vld;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_data;
    logic [SW-1:0] ptr_next;
    int            sum;
    logic [SW-1:0] idx;

`ifdef MUX_RR_STREAM_LAST_LOCK_EN
    logic lock;
`endif

    assign load = !valid_out || ready_in;

    // Scan from the farthest offset down so the nearest valid channel to ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = 0;
        idx       = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            sum = int'(ptr) + k;
            if (sum >= CH) sum = sum - CH;
            idx = SW'(sum);
            if (valid_in[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
        // sel_out still names the channel whose packet is open.
        if (lock) begin
            grant_vld = valid_in[sel_out];
            grant_idx = sel_out;
        end
`endif
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (grant_idx == SW'(i)) grant_data = d_in[i*W +: W];
        end
    end

    always_comb begin
        ready_out = '0;
        if (load && grant_vld && !rst_in) ready_out[grant_idx] = 1'b1;
    end

    assign ptr_next = (grant_idx == SW'(CH - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_out <= 1'b0;
            out       <= '0;
            sel_out   <= '0;
            ptr       <= '0;
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
            lock      <= 1'b0;
            last_out  <= 1'b0;
`endif
        end else if (load) begin
            if (grant_vld) begin
                valid_out <= 1'b1;
                out       <= grant_data;
                sel_out   <= grant_idx;
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
                lock      <= !last_in[grant_idx];
                last_out  <= last_in[grant_idx];
                if (last_in[grant_idx]) ptr <= ptr_next;
`else
                ptr       <= ptr_next;
`endif
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Directed bench for mux_rr_stream: a CH=4 instance plus a CH=3 instance for wrap checks.
module tb_mux_rr_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] d;
    logic [3:0]  v, rdy;
    logic [7:0]  o;
    logic        vo, ri;
    logic [1:0]  sel;
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
    logic [3:0]  li;
    logic        lo;
`endif

    logic        rst_b;
    logic [23:0] d_b;
    logic [2:0]  v_b, rdy_b;
    logic [7:0]  o_b;
    logic        vo_b, ri_b;
    logic [1:0]  sel_b;
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
    logic [2:0]  li_b;
    logic        lo_b;
`endif

    int checks = 0;
    int failures = 0;

    mux_rr_stream #(.CH(4), .W(8)) dut (
        .clk_in(clk), .rst_in(rst), .d_in(d), .valid_in(v), .ready_out(rdy),
        .out(o), .valid_out(vo), .ready_in(ri),
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
        .last_in(li), .last_out(lo),
`endif
        .sel_out(sel)
    );

    mux_rr_stream #(.CH(3), .W(8)) dut3 (
        .clk_in(clk), .rst_in(rst_b), .d_in(d_b), .valid_in(v_b), .ready_out(rdy_b),
        .out(o_b), .valid_out(vo_b), .ready_in(ri_b),
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
        .last_in(li_b), .last_out(lo_b),
`endif
        .sel_out(sel_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; d = 32'h44332211; v = 4'hF; ri = 1'b1;
        rst_b = 1'b1; d_b = 24'hC2B1A0; v_b = 3'b000; ri_b = 1'b1;
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
        li = 4'hF; li_b = 3'h7;
`endif
        #1;
        chk("rst_ready_comb", rdy, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("rst_valid", vo, 1'b0);
            chk("rst_out", o, 8'h00);
            chk("rst_sel", sel, 2'd0);
            chk("rst_ready", rdy, 4'b0000);
        end

        // round robin, all channels valid
        rst = 1'b0; rst_b = 1'b0;
        #1;
        chk("rr_ready0", rdy, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("rr_valid", vo, 1'b1);
            chk("rr_out", o, 64'(8'h11 * ((i % 4) + 1)));
            chk("rr_sel", sel, 64'(i % 4));
        end
        tick;
        chk("bp_load_out", o, 8'h22);
        chk("bp_load_sel", sel, 2'd1);

        // backpressure holds the beat
        ri = 1'b0;
        #1;
        chk("bp_ready_comb", rdy, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("bp_out", o, 8'h22);
            chk("bp_sel", sel, 2'd1);
            chk("bp_valid", vo, 1'b1);
            chk("bp_ready", rdy, 4'b0000);
        end
        ri = 1'b1;
        #1;
        chk("bp_release_ready", rdy, 4'b0100);
        tick;
        chk("bp_next_out", o, 8'h33);
        chk("bp_next_sel", sel, 2'd2);

        // idle: valid drops, data holds
        v = 4'b0000;
        #1;
        chk("idle_ready", rdy, 4'b0000);
        tick;
        chk("idle_valid", vo, 1'b0);
        chk("idle_out", o, 8'h33);
        chk("idle_sel", sel, 2'd2);

        // sparse channels 1 and 3, ptr=3
        v = 4'b1010;
        #1;
        chk("sparse_ready3", rdy, 4'b1000);
        tick;
        chk("sparse_sel_a", sel, 2'd3);
        chk("sparse_out_a", o, 8'h44);
        chk("sparse_ready1", rdy, 4'b0010);
        tick;
        chk("sparse_sel_b", sel, 2'd1);
        tick;
        chk("sparse_sel_c", sel, 2'd3);

        // mid-stream reset discards the held beat
        rst = 1'b1;
        #1;
        chk("mrst_ready_comb", rdy, 4'b0000);
        tick;
        chk("mrst_valid", vo, 1'b0);
        chk("mrst_out", o, 8'h00);
        chk("mrst_sel", sel, 2'd0);
        v = 4'b0110; rst = 1'b0;
        #1;
        chk("mrst_first_ready", rdy, 4'b0010);
        tick;
        chk("mrst_first_sel", sel, 2'd1);
        chk("mrst_first_out", o, 8'h22);
        v = 4'b0000;

        // CH=3 wrap: move ptr to 1, then channels 0 and 2 alternate
        v_b = 3'b001;
        #1;
        chk("w3_ready0", rdy_b, 3'b001);
        tick;
        chk("w3_sel0", sel_b, 2'd0);
        chk("w3_out0", o_b, 8'hA0);
        v_b = 3'b101;
        #1;
        chk("w3_ready2", rdy_b, 3'b100);
        tick;
        chk("w3_sel_a", sel_b, 2'd2);
        chk("w3_out_a", o_b, 8'hC2);
        chk("w3_wrap_ready", rdy_b, 3'b001);
        tick;
        chk("w3_sel_b", sel_b, 2'd0);
        tick;
        chk("w3_sel_c", sel_b, 2'd2);
        chk("w3_valid", vo_b, 1'b1);
        v_b = 3'b000;

`ifdef MUX_RR_STREAM_LAST_LOCK_EN
        // packet lock on channel 1 while 0 and 2 stay valid
        rst = 1'b1; v = 4'b0111; li = 4'b1111;
        tick;
        rst = 1'b0;
        tick;
        chk("lk_sel_pre", sel, 2'd0);
        li = 4'b1101;
        tick;
        chk("lk_sel_1", sel, 2'd1);
        chk("lk_last_1", lo, 1'b0);
        tick;
        chk("lk_sel_2", sel, 2'd1);
        chk("lk_last_2", lo, 1'b0);
        li = 4'b1111;
        tick;
        chk("lk_sel_3", sel, 2'd1);
        chk("lk_last_3", lo, 1'b1);
        tick;
        chk("lk_sel_after", sel, 2'd2);
        // lock ch0, then reset mid-packet
        li = 4'b1110;
        tick;
        chk("lk_sel_open", sel, 2'd0);
        chk("lk_last_open", lo, 1'b0);
        rst = 1'b1; v = 4'b0110;
        tick;
        chk("lk_rst_valid", vo, 1'b0);
        chk("lk_rst_last", lo, 1'b0);
        rst = 1'b0;
        #1;
        chk("lk_rst_ready", rdy, 4'b0010);
        tick;
        chk("lk_rst_sel", sel, 2'd1);
        v = 4'b0000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_rr_stream.md
MUX_RR_STREAM -- requirements
Module: mux_rr_stream

Interface
REQ-001 SHALL have parameter CH, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter W, default 8, data width per channel (1..64).
REQ-003 SHALL have port clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-005 SHALL have port d_in  input  CH*W  packed channel data; channel i occupies d_in[i*W +: W].
REQ-006 SHALL have port valid_in  input  CH  per-channel data valid.
REQ-007 SHALL have port ready_out  output  CH  per-channel accept strobe.
REQ-008 SHALL have port out  output  W  registered selected data.
REQ-009 SHALL have port valid_out  output  1  out holds a beat.
REQ-010 SHALL have port ready_in  input  1  downstream accepts out this cycle.
REQ-011 SHALL have port sel_out  output  clog2(CH)  channel index of the beat in out.

Function
REQ-012 SHALL define load = !valid_out || ready_in; the output register accepts a new beat only when load is 1.
REQ-013 SHALL perform round-robin arbitration: scan channels ptr, ptr+1, ... wrapping modulo CH; grant the first with valid_in set.
REQ-014 SHALL drive ready_out combinationally: ready_out[g] = load && (g is granted); all other bits 0; at most one bit set.
REQ-015 SHALL, on an input transfer from channel g (valid_in[g] && ready_out[g]), load out <= d_in[g], sel_out <= g, valid_out <= 1, and set ptr <= (g+1) mod CH.
REQ-016 SHALL, when load is 1 and no valid_in is set, clear valid_out at the next edge; out and sel_out hold their previous values.
REQ-017 SHALL, when valid_out && !ready_in, hold out, sel_out, valid_out and ptr unchanged and drive ready_out = 0.
REQ-018 SHALL have latency of exactly 1 cycle from input transfer to valid_out; sustained throughput 1 beat/cycle with ready_in held high.
REQ-019 SHALL treat valid_in and ready_in deasserting simultaneously with a transfer as ordinary: the transfer completes if ready_out was 1 in that cycle.
REQ-020 SHALL guarantee no starvation: a channel holding valid_in is granted within CH transfers.
REQ-021 SHALL, when CH is not a power of two, wrap ptr from CH-1 to 0; ptr never holds a value >= CH.

Reset
REQ-022 SHALL, with rst_in high at a rising edge, set valid_out=0, out=0, sel_out=0, ptr=0, and (when compiled in) lock=0.
REQ-023 SHALL drive ready_out=0 whenever rst_in is high; a beat presented during reset is not consumed.
REQ-024 SHALL, on reset mid-stream, discard any held beat in out without handshake; first grant after reset starts scanning at channel 0.

Configuration
REQ-025 SHALL compile packet locking in only when macro MUX_RR_STREAM_LAST_LOCK_EN is defined.
REQ-026 SHALL, with the macro defined, add ports last_in (input, CH, per-channel end-of-packet) and last_out (output, 1, registered with out, reset 0).
REQ-027 SHALL, with the macro defined, set lock on a transfer with last_in[g]=0 and clear it on a transfer with last_in[g]=1; while lock is set, the grant stays on the locked channel regardless of other valid_in, and ptr advances only on the last beat.
REQ-028 SHALL, without the macro, have no last ports and re-arbitrate on every beat per REQ-013.

Verification
REQ-029 Reset: rst_in=1 two cycles with valid_in=4'b1111 -> ready_out=0, valid_out=0, out=0, sel_out=0.
REQ-030 Round-robin: CH=4, all valid, d_in={8'h44,8'h33,8'h22,8'h11}, ready_in=1 -> out sequence 11,22,33,44,11 with sel_out 0,1,2,3,0 on consecutive cycles.
REQ-031 Backpressure: beat 8'h22 in out, ready_in=0 for 3 cycles -> out=22, sel_out=1, valid_out=1 held, ready_out=0; ready_in=1 -> next channel loads in the following cycle.
REQ-032 Sparse/wrap: CH=3, only valid_in[2] and valid_in[0] set, ptr=1 -> grants 2 then 0 then 2; ptr never reaches 3.
REQ-033 Lock (macro defined): ch1 sends 3 beats last_in=0,0,1 while ch0,ch2 valid -> three consecutive beats sel_out=1, last_out=0,0,1, then sel_out=2.
REQ-034 Mid-stream reset: rst_in=1 while valid_out=1 and lock set -> next cycle valid_out=0, lock=0, first subsequent grant is lowest valid channel.
